gendelaymerge2: RTL and testbench
=================================

# gendelaymerge2

Two-input round-robin merge stage placed directly downstream of a pair of delay queues in the c2 hardware backend. Each cycle it pops at most one word from one of the two queues. It tags the word with its source and holds it in a 2-entry output buffer that drives a valid/ready consumer. The buffer is registered, so `out_ready` has no combinational path to either pop strobe. Per-source 16-bit grant counters are exported for debug and performance monitoring.

## Interface
Parameters:
- `WIDTH`, 8, data word width
- `CNTW`, 16, width of the per-source grant counters

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-high
- `a_valid`  in  1  queue A has a valid word on `a_data` this cycle
- `a_data`  in  WIDTH  queue A head word
- `a_re`  out  1  pop strobe to queue A; the word on `a_data` is consumed this cycle
- `b_valid`  in  1  queue B has a valid word on `b_data` this cycle
- `b_data`  in  WIDTH  queue B head word
- `b_re`  out  1  pop strobe to queue B
- `out_valid`  out  1  buffer head is valid
- `out_data`  out  WIDTH  buffer head word
- `out_src`  out  1  source of the head word: 0 = A, 1 = B
- `out_ready`  in  1  consumer accepts the head word this cycle
- `occ`  out  2  buffer occupancy, 0..2
- `cnt_a`  out  CNTW  number of words popped from A since reset, wraps
- `cnt_b`  out  CNTW  number of words popped from B since reset, wraps

## Operation
- Buffer: two entries of {src, data} held as FIFO, with occupancy states EMPTY(0), ONE(1), TWO(2). The head entry drives `out_*`.
- `pop_out` = `out_valid & out_ready`.
- `push` = `a_re | b_re`.
- `can_push` = (`occ` != 2) & ~`rst`. It is derived from registered state only.
- Arbitration uses a registered `last` bit, the source of the most recent grant. Its reset value is 1 (B), so A wins the first tie.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the source opposite to `last`.
  - `a_re` and `b_re` are one-hot or zero, and are asserted only when `can_push` holds.
  - `last` updates only on a grant.
- Occupancy transitions:
  - EMPTY + push → ONE.
  - ONE + push only → TWO.
  - ONE + pop only → EMPTY.
  - ONE + push and pop together → ONE, with the new word becoming the head.
  - TWO + pop → ONE, with entry 1 shifting to the head.
  - TWO never pushes.
- Simultaneous push and pop in state ONE yields a throughput of 1 word/clk.
- Word order is preserved: output order equals grant order.
- Counters: `cnt_a` increments on `a_re` and `cnt_b` on `b_re`, each modulo 2^CNTW.
- Reset: `occ`=0, `out_valid`=0, `out_data`=0, `out_src`=0, `last`=1, `cnt_a`=`cnt_b`=0.
  - `a_re`=`b_re`=0 during any cycle with `rst` high, including a mid-operation reset.
  - Buffered words are discarded.
  - Words not yet popped stay in the upstream queues.
- `out_data`/`out_src` are don't-care when `out_valid`=0, but they must not change while `out_valid`=1 and `out_ready`=0.

## Timing
- Latency: a word popped in cycle N appears on `out_*` at N+1, when the buffer was EMPTY or became the head via push+pop.
- Combinational paths:
  - `a_re`/`b_re` depend only on `a_valid`, `b_valid`, `last`, `occ` and `rst`.
  - No path from `out_ready` to `a_re`/`b_re`.
- `out_valid` is registered. It falls the cycle after the last pop only if no push occurred in the same cycle.
- Backpressure: with `out_ready`=0, at most 2 further pops occur, then `a_re`=`b_re`=0 until a pop frees an entry. Pushing resumes the cycle after the first `pop_out`, because `occ` is registered.
- Counter values are visible the cycle after the grant.

## Test plan
- Reset then idle: hold `rst`=1 for 2 clk with `a_valid`=`b_valid`=1 → `a_re`=`b_re`=0 and all outputs 0. On the first cycle after release, `a_re`=1 (A wins the tie).
- Alternation: both inputs always valid with A words 0x10,0x11,… and B words 0x20,0x21,…, `out_ready`=1 → output stream 0x10,0x20,0x11,0x21,… at 1 word/clk, `out_src` alternating 0,1, `occ` steady at 1.
- Single source: only `b_valid`=1 for 5 cycles → 5 consecutive B grants, `cnt_b`=5, `cnt_a`=0.
- Backpressure: stream from A with `out_ready`=0 → exactly 2 pops, `occ`=2, `a_re` low thereafter and `out_data` stable. Raising `out_ready` for 1 cycle → `occ`=1 next cycle, then a pop resumes with no word lost or duplicated.
- Counter wrap: with `CNTW`=4, 17 pops from A → `cnt_a`=1.
- Mid-operation reset: assert `rst` for 1 cycle with `occ`=2 → next cycle `occ`=0, `out_valid`=0, counters 0, and no `a_re`/`b_re` during the reset cycle.

Source files
------------

// File: rtl/gendelaymerge2_if.sv
// Handshake bundle between the two delay-queue heads, the merge stage and its consumer.
// master = merge stage, slave = queues/consumer side.
interface gendelaymerge2_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_re;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_re;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport master (
        input  a_valid, a_data,
        output a_re,
        input  b_valid, b_data,
        output b_re,
        output out_valid, out_data, out_src,
        input  out_ready
    );

    modport slave (
        output a_valid, a_data,
        input  a_re,
        output b_valid, b_data,
        input  b_re,
        input  out_valid, out_data, out_src,
        output out_ready
    );
endinterface

// File: rtl/gendelaymerge2.sv
// Round-robin merge of two delay-queue heads into a registered 2-entry tagged FIFO.
// Pop strobes depend only on registered state and input valids, never on out_ready.
module gendelaymerge2 #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    gendelaymerge2_if.master bus,
    output logic [1:0]      occ,
    output logic [CNTW-1:0] cnt_a,
    output logic [CNTW-1:0] cnt_b
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q;
    logic [WIDTH-1:0] d0_q, d1_q;
    logic             s0_q, s1_q;
    logic             can_push, grant_a, grant_b, push, pop_out;
    logic             ld_head, ld_tail, shift;
    logic [WIDTH-1:0] in_data;

    // Tie goes to the source that did not win last time.
    function automatic logic pick_b(input logic av, input logic bv, input logic last);
        return bv & (~av | ~last);
    endfunction

    assign can_push = (state_q != TWO) & ~rst;
    assign grant_b  = can_push & pick_b(bus.a_valid, bus.b_valid, last_q);
    assign grant_a  = can_push & bus.a_valid & ~pick_b(bus.a_valid, bus.b_valid, last_q);
    assign push     = grant_a | grant_b;
    assign in_data  = grant_b ? bus.b_data : bus.a_data;

    assign bus.a_re      = grant_a;
    assign bus.b_re      = grant_b;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = d0_q;
    assign bus.out_src   = s0_q;
    assign pop_out       = bus.out_valid & bus.out_ready;
    assign occ           = state_q;

    always_comb begin
        state_d = state_q;
        ld_head = 1'b0;
        ld_tail = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    ld_head = 1'b1;
                end
            end
            ONE: begin
                if (push && pop_out) begin
                    ld_head = 1'b1;
                end else if (push) begin
                    state_d = TWO;
                    ld_tail = 1'b1;
                end else if (pop_out) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop_out) begin
                    state_d = ONE;
                    shift   = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Control state: occupancy, arbitration history, grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            last_q  <= 1'b1;
            cnt_a   <= '0;
            cnt_b   <= '0;
        end else begin
            state_q <= state_d;
            if (push) last_q <= grant_b;
            if (grant_a) cnt_a <= cnt_a + CNTW'(1);
            if (grant_b) cnt_b <= cnt_b + CNTW'(1);
        end
    end

    // Head entry is cleared on reset so the outputs read zero; the tail is only
    // ever read after being loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            d0_q <= '0;
            s0_q <= 1'b0;
        end else if (ld_head) begin
            d0_q <= in_data;
            s0_q <= grant_b;
        end else if (shift) begin
            d0_q <= d1_q;
            s0_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_tail) begin
            d1_q <= in_data;
            s1_q <= grant_b;
        end
    end
endmodule

// File: tb/tb_gendelaymerge2.sv
// Self-checking bench for gendelaymerge2: table-driven vectors plus a scoreboard of granted words.
module tb_gendelaymerge2;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  occ, w_occ;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  w_cnt_a, w_cnt_b;

    int checks = 0;
    int errors = 0;

    gendelaymerge2_if #(.WIDTH(8)) bus ();
    gendelaymerge2_if #(.WIDTH(8)) wbus ();

    gendelaymerge2 #(.WIDTH(8), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.master), .occ(occ), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    gendelaymerge2 #(.WIDTH(8), .CNTW(4)) u_wrap (
        .clk(clk), .rst(rst), .bus(wbus.master), .occ(w_occ), .cnt_a(w_cnt_a), .cnt_b(w_cnt_b)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [8:0] sb[$];
    int         m_occ = 0;
    logic       m_last = 1'b1;
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;
    logic [7:0] a_next = 8'h10;
    logic [7:0] b_next = 8'h20;

    typedef struct {
        logic       r, av, bv, rdy;
        logic       ea, eb, ev;
        int         eocc;
        logic [8:0] ew;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs before the next posedge, advance model.
    task automatic step(input logic r, input logic av, input logic bv, input logic rdy);
        logic       cp, ga, gb, pop;
        logic [8:0] exp;
        @(negedge clk);
        rst           = r;
        bus.a_valid   = av;
        bus.a_data    = a_next;
        bus.b_valid   = bv;
        bus.b_data    = b_next;
        bus.out_ready = rdy;
        #1;
        cp = (m_occ != 2) && !r;
        ga = cp && av && (!bv || m_last);
        gb = cp && bv && (!av || !m_last);
        chk("a_re", bus.a_re, ga);
        chk("b_re", bus.b_re, gb);
        chk("occ", occ, m_occ);
        chk("out_valid", bus.out_valid, m_occ != 0);
        chk("cnt_a", cnt_a, m_cnt_a & 16'hffff);
        chk("cnt_b", cnt_b, m_cnt_b & 16'hffff);
        pop = (m_occ != 0) && rdy;
        if (pop) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual=%0h expected=none", {bus.out_src, bus.out_data});
            end else begin
                exp = sb.pop_front();
                chk("out_word", {bus.out_src, bus.out_data}, exp);
            end
        end
        if (r) begin
            sb.delete();
            m_occ   = 0;
            m_last  = 1'b1;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            if (ga) begin
                sb.push_back({1'b0, a_next});
                a_next++;
                m_cnt_a++;
                m_last = 1'b0;
            end
            if (gb) begin
                sb.push_back({1'b1, b_next});
                b_next++;
                m_cnt_b++;
                m_last = 1'b1;
            end
            m_occ = m_occ + ((ga || gb) ? 1 : 0) - (pop ? 1 : 0);
        end
    endtask

    initial begin
        //          r   av  bv  rdy ea  eb  ev  occ word
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 9'h000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h010};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 9'h120};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h011};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 9'h121};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h012};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 9'h122};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 9'h000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h123};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h124};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h125};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h126};

        rst            = 1'b1;
        bus.a_valid    = 1'b0;
        bus.a_data     = '0;
        bus.b_valid    = 1'b0;
        bus.b_data     = '0;
        bus.out_ready  = 1'b0;
        wbus.a_valid   = 1'b0;
        wbus.a_data    = 8'h55;
        wbus.b_valid   = 1'b0;
        wbus.b_data    = 8'h66;
        wbus.out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Reset held with both sources requesting: no pops.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].av, tbl[i].bv, tbl[i].rdy);
            chk($sformatf("tbl%0d_a_re", i), bus.a_re, tbl[i].ea);
            chk($sformatf("tbl%0d_b_re", i), bus.b_re, tbl[i].eb);
            chk($sformatf("tbl%0d_occ", i), occ, tbl[i].eocc);
            chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].ev);
            if (tbl[i].ev)
                chk($sformatf("tbl%0d_word", i), {bus.out_src, bus.out_data}, tbl[i].ew);
            if (i == 0) begin
                chk("rst_out_data", bus.out_data, 8'h00);
                chk("rst_out_src", bus.out_src, 1'b0);
                chk("rst_cnt_a", cnt_a, 16'd0);
                chk("rst_cnt_b", cnt_b, 16'd0);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("single_cnt_b", cnt_b, 16'd5);
        chk("single_cnt_a", cnt_a, 16'd0);

        // Backpressure from A with the consumer stalled.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_full_occ", occ, 2'd2);
        chk("bp_full_are", bus.a_re, 1'b0);
        chk("bp_head", bus.out_data, 8'h13);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_stable", bus.out_data, 8'h13);
        chk("bp_still_blocked", bus.a_re, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("bp_pop_no_push", bus.a_re, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_resume_occ", occ, 2'd1);
        chk("bp_resume_are", bus.a_re, 1'b1);
        chk("bp_resume_head", {bus.out_src, bus.out_data}, 9'h014);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_last_word", {bus.out_src, bus.out_data}, 9'h015);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drained_occ", occ, 2'd0);
        chk("bp_drained_valid", bus.out_valid, 1'b0);
        chk("bp_cnt_a", cnt_a, 16'd3);

        // Reset while the buffer is full.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_occ_before", occ, 2'd2);
        chk("mid_rst_are", bus.a_re, 1'b0);
        chk("mid_rst_bre", bus.b_re, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_occ", occ, 2'd0);
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_cnt_a", cnt_a, 16'd0);
        chk("mid_rst_cnt_b", cnt_b, 16'd0);

        // Counter wrap on the CNTW=4 instance: 17 back-to-back A pops.
        chk("wrap_start", w_cnt_a, 4'd0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wbus.a_valid = 1'b1;
            #1;
            chk($sformatf("wrap_are%0d", i), wbus.a_re, 1'b1);
        end
        @(negedge clk);
        wbus.a_valid = 1'b0;
        #1;
        chk("wrap_cnt_a", w_cnt_a, 4'd1);
        chk("wrap_cnt_b", w_cnt_b, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
